lfsr_prbs_gen: RTL and testbench



---
 rtl/lfsr_prbs_gen.sv | 76 +++++++
 tb/tb_lfsr_prbs_gen.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/lfsr_prbs_gen.sv
// lfsr_prbs_gen: XNOR LFSR PRBS word generator with valid/ready output and period tracking.
// Define LFSR_ERR_INJECT_EN to add i_Inject, which flips o_Data[0] of a generated word.
module lfsr_prbs_gen #(
    parameter int NUM_BITS = 16,
    parameter logic [NUM_BITS-1:0] TAPS = 16'hD008,
    parameter int WORD_BITS = 8,
    parameter logic [NUM_BITS-1:0] INIT_SEED = '0
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst,
    input  logic                 i_Enable,
    input  logic                 i_Seed_DV,
    input  logic [NUM_BITS-1:0]  i_Seed_Data,
`ifdef LFSR_ERR_INJECT_EN
    input  logic                 i_Inject,
`endif
    output logic [WORD_BITS-1:0] o_Data,
    output logic                 o_Valid,
    input  logic                 i_Ready,
    output logic                 o_Wrap,
    output logic                 o_Seed_Err,
    output logic [NUM_BITS-1:0]  o_State
);
    localparam logic [NUM_BITS:0] PERIOD = {1'b0, {NUM_BITS{1'b1}}};
    localparam logic [NUM_BITS:0] STEP = (NUM_BITS+1)'(WORD_BITS);
    logic [NUM_BITS-1:0] state, nxt;
    logic [NUM_BITS:0] cnt, sum, cnt_n;
    logic [WORD_BITS-1:0] bits, word;
    logic gen, wrap_n;
    always_comb begin
        nxt = state;
        bits = '0;
        for (int k = 0; k < WORD_BITS; k++) begin
            bits[WORD_BITS-1-k] = ~^(nxt & TAPS);
            nxt = {nxt[NUM_BITS-2:0], bits[WORD_BITS-1-k]};
        end
    end
`ifdef LFSR_ERR_INJECT_EN
    assign word = bits ^ WORD_BITS'(i_Inject);
`else
    assign word = bits;
`endif
    assign sum = cnt + STEP;
    assign wrap_n = sum >= PERIOD;
    assign cnt_n = wrap_n ? sum - PERIOD : sum;
    assign gen = i_Enable & (~o_Valid | i_Ready);
    assign o_State = state;
    // all-ones seed would lock the XNOR LFSR, so it is replaced by zero
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state <= INIT_SEED;
            cnt <= '0;
            o_Data <= '0;
            o_Valid <= 1'b0;
            o_Wrap <= 1'b0;
            o_Seed_Err <= 1'b0;
        end else if (i_Seed_DV) begin
            state <= &i_Seed_Data ? '0 : i_Seed_Data;
            cnt <= '0;
            o_Valid <= 1'b0;
            o_Wrap <= 1'b0;
            o_Seed_Err <= &i_Seed_Data;
        end else begin
            o_Seed_Err <= 1'b0;
            if (gen) begin
                state <= nxt;
                cnt <= cnt_n;
                o_Data <= word;
                o_Valid <= 1'b1;
                o_Wrap <= wrap_n;
            end else if (o_Valid && i_Ready) begin
                o_Valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_lfsr_prbs_gen.sv
// tb_lfsr_prbs_gen: directed vectors for 3-bit (1- and 4-bit words) and default 16-bit generators.
module tb_lfsr_prbs_gen;
    logic clk = 0, rst = 1, en = 0, rdy = 0, sdv = 0, inj = 0;
    logic [2:0] seed3 = '0;
    logic [15:0] seed16 = '0;
    logic a_data, a_valid, a_wrap, a_err;
    logic [2:0] a_state;
    logic [3:0] b_data;
    logic b_valid, b_wrap, b_err;
    logic [2:0] b_state;
    logic [7:0] c_data;
    logic c_valid, c_wrap, c_err;
    logic [15:0] c_state;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    lfsr_prbs_gen #(.NUM_BITS(3), .TAPS(3'b110), .WORD_BITS(1), .INIT_SEED(3'b000)) u_a (
        .i_Clk(clk), .i_Rst(rst), .i_Enable(en), .i_Seed_DV(sdv), .i_Seed_Data(seed3),
`ifdef LFSR_ERR_INJECT_EN
        .i_Inject(inj),
`endif
        .o_Data(a_data), .o_Valid(a_valid), .i_Ready(rdy), .o_Wrap(a_wrap),
        .o_Seed_Err(a_err), .o_State(a_state));

    lfsr_prbs_gen #(.NUM_BITS(3), .TAPS(3'b110), .WORD_BITS(4), .INIT_SEED(3'b000)) u_b (
        .i_Clk(clk), .i_Rst(rst), .i_Enable(en), .i_Seed_DV(sdv), .i_Seed_Data(seed3),
`ifdef LFSR_ERR_INJECT_EN
        .i_Inject(inj),
`endif
        .o_Data(b_data), .o_Valid(b_valid), .i_Ready(rdy), .o_Wrap(b_wrap),
        .o_Seed_Err(b_err), .o_State(b_state));

    lfsr_prbs_gen u_c (
        .i_Clk(clk), .i_Rst(rst), .i_Enable(en), .i_Seed_DV(1'b0), .i_Seed_Data(seed16),
`ifdef LFSR_ERR_INJECT_EN
        .i_Inject(1'b0),
`endif
        .o_Data(c_data), .o_Valid(c_valid), .i_Ready(rdy), .o_Wrap(c_wrap),
        .o_Seed_Err(c_err), .o_State(c_state));

    typedef struct {
        logic en, rdy, valid, a_data, a_wrap;
        logic [2:0] a_state;
        logic [3:0] b_data;
        logic b_wrap;
        logic [2:0] b_state;
    } vec_t;
    vec_t tbl[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n, wraps, first_wrap, second_wrap, lost;
        logic [15:0] st8192;
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 4'b0000, 1'b0, 3'b000};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b001, 4'b1101, 1'b0, 3'b101};
        for (int i = 2; i < 7; i++)
            tbl[i] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'b001, 4'b1101, 1'b0, 3'b101};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'b001, 4'b1101, 1'b0, 3'b101};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b011, 4'b0001, 1'b1, 3'b001};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b110, 4'b1010, 1'b0, 3'b010};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b110, 4'b0000, 1'b0, 3'b010};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'b101, 4'b0011, 1'b1, 3'b011};
        tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b010, 4'b0100, 1'b0, 3'b100};
        tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b100, 4'b0110, 1'b1, 3'b110};
        tbl[14] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'b000, 4'b1000, 1'b1, 3'b000};
        tbl[15] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b001, 4'b1101, 1'b0, 3'b101};

        step();
        chk("rst_a_valid", a_valid, 0);
        chk("rst_a_data", a_data, 0);
        chk("rst_a_wrap", a_wrap, 0);
        chk("rst_a_err", a_err, 0);
        chk("rst_a_state", a_state, 0);
        chk("rst_b_data", b_data, 0);
        chk("rst_b_valid", b_valid, 0);
        rst = 0;

        for (int i = 0; i < 16; i++) begin
            en = tbl[i].en;
            rdy = tbl[i].rdy;
            step();
            chk($sformatf("v%0d_a_valid", i), a_valid, tbl[i].valid);
            chk($sformatf("v%0d_b_valid", i), b_valid, tbl[i].valid);
            chk($sformatf("v%0d_a_state", i), a_state, tbl[i].a_state);
            chk($sformatf("v%0d_b_state", i), b_state, tbl[i].b_state);
            if (tbl[i].valid) begin
                chk($sformatf("v%0d_a_data", i), a_data, tbl[i].a_data);
                chk($sformatf("v%0d_a_wrap", i), a_wrap, tbl[i].a_wrap);
                chk($sformatf("v%0d_b_data", i), b_data, tbl[i].b_data);
                chk($sformatf("v%0d_b_wrap", i), b_wrap, tbl[i].b_wrap);
            end
        end

        en = 0; rdy = 0; sdv = 1; seed3 = 3'b111;
        step();
        chk("bad_seed_a_valid", a_valid, 0);
        chk("bad_seed_b_valid", b_valid, 0);
        chk("bad_seed_a_state", a_state, 0);
        chk("bad_seed_b_state", b_state, 0);
        chk("bad_seed_a_err", a_err, 1);
        chk("bad_seed_b_err", b_err, 1);
        chk("bad_seed_a_wrap", a_wrap, 0);
        sdv = 0;
        step();
        chk("bad_seed_err_pulse", a_err, 0);
        chk("bad_seed_valid_hold", a_valid, 0);

        sdv = 1; seed3 = 3'b101; en = 1; rdy = 1;
        step();
        chk("seed_a_valid", a_valid, 0);
        chk("seed_a_state", a_state, 3'b101);
        chk("seed_a_err", a_err, 0);
        sdv = 0;
        step();
        chk("seed_w1_a_valid", a_valid, 1);
        chk("seed_w1_a_data", a_data, 0);
        chk("seed_w1_a_state", a_state, 3'b010);
        chk("seed_w1_b_data", b_data, 4'b0001);
        chk("seed_w1_b_state", b_state, 3'b001);
        chk("seed_w1_b_wrap", b_wrap, 0);

`ifdef LFSR_ERR_INJECT_EN
        inj = 1;
        step();
        chk("inj_b_data", b_data, 4'b1011);
        chk("inj_b_state", b_state, 3'b010);
        inj = 0;
        step();
        chk("post_inj_b_data", b_data, 4'b0011);
        chk("post_inj_b_state", b_state, 3'b011);
`endif

        en = 0; rst = 1;
        step();
        chk("c_rst_valid", c_valid, 0);
        chk("c_rst_data", c_data, 0);
        chk("c_rst_state", c_state, 0);
        chk("c_rst_wrap", c_wrap, 0);
        rst = 0; en = 1; rdy = 1;
        step();
        chk("c_w1_valid", c_valid, 1);
        chk("c_w1_data", c_data, 8'hF0);
        chk("c_w1_state", c_state, 16'h00F0);
        chk("c_w1_wrap", c_wrap, 0);

        n = 1; wraps = 0; first_wrap = 0; second_wrap = 0; lost = 0; st8192 = '0;
        for (int k = 0; k < 16383; k++) begin
            step();
            n++;
            if (!c_valid) lost++;
            if (c_wrap) begin
                wraps++;
                if (first_wrap == 0) first_wrap = n;
                else if (second_wrap == 0) second_wrap = n;
            end
            if (n == 8192) st8192 = c_state;
        end
        chk("c_first_wrap_word", first_wrap, 8192);
        chk("c_second_wrap_word", second_wrap, 16384);
        chk("c_wrap_count", wraps, 2);
        chk("c_state_after_period", st8192, 16'h0001);
        chk("c_valid_gaps", lost, 0);

        rst = 1;
        step();
        chk("c_mid_rst_valid", c_valid, 0);
        chk("c_mid_rst_data", c_data, 0);
        chk("c_mid_rst_wrap", c_wrap, 0);
        chk("c_mid_rst_state", c_state, 0);
        chk("c_mid_rst_err", c_err, 0);
        rst = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
